// File: rtl/dijkstra_relax_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dijkstra_relax_ctrl
// Description : Edge relaxation controller for one Dijkstra node expansion.
//               Pulls edges from a ready/valid stream, hands each one to an
//               external float check-step (node_dist + weight), and reports
//               a distance update when the candidate beats the current
//               neighbour distance.
// Revision    : 1.0 - initial release
// ============================================================================
module dijkstra_relax_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] node_dist,
  input  logic [7:0]  edge_count,
  input  logic        edge_valid,
  output logic        edge_ready,
  input  logic [31:0] edge_weight,
  input  logic [31:0] edge_cur_dist,
  input  logic [7:0]  edge_idx,
  output logic        cs_start,
  output logic [31:0] cs_dataa,
  output logic [31:0] cs_datab,
  input  logic        cs_done,
  input  logic [31:0] cs_result,
  output logic        upd_valid,
  output logic [7:0]  upd_idx,
  output logic [31:0] upd_dist,
  output logic        busy,
  output logic        done,
  output logic [7:0]  upd_count,
  output logic        timeout_err
);

  // +infinity in IEEE-754 single; anything above it is a NaN encoding.
  localparam logic [31:0] c_FP_INF    = 32'h7F800000;
  // Watchdog value reached on the eighth enabled WAIT cycle.
  localparam logic [3:0]  c_WDOG_LAST = 4'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    WAIT   = 3'd3,
    EVAL   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] nd_r;
  logic [7:0]  remaining_r;
  logic [31:0] cand_r;
  logic [31:0] r_weight;
  logic [31:0] r_cur_dist;
  logic [7:0]  r_idx;
  logic [3:0]  r_wdog;
  logic        r_upd_valid;
  logic        r_done;
  logic        w_improve;

  // Non-negative floats order like unsigned integers, so a plain integer
  // compare suffices once infinity/NaN on either side are excluded.
  assign w_improve = (cand_r <= c_FP_INF) && (r_cur_dist <= c_FP_INF) &&
                     (cand_r < r_cur_dist);

  // Decoded handshake/status outputs; pulses are suppressed while stalled.
  assign edge_ready = (r_state == FETCH);
  assign busy       = (r_state != IDLE);
  assign cs_start   = (r_state == ISSUE) && clk_en;
  assign cs_dataa   = (r_state == IDLE) ? 32'd0 : nd_r;
  assign cs_datab   = (r_state == IDLE) ? 32'd0 : r_weight;
  assign upd_valid  = r_upd_valid && clk_en;
  assign done       = r_done && clk_en;

  // Relaxation pass sequencer with its datapath latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      nd_r        <= 32'd0;
      remaining_r <= 8'd0;
      cand_r      <= 32'd0;
      r_weight    <= 32'd0;
      r_cur_dist  <= 32'd0;
      r_idx       <= 8'd0;
      r_wdog      <= 4'd0;
      r_upd_valid <= 1'b0;
      r_done      <= 1'b0;
      upd_idx     <= 8'd0;
      upd_dist    <= 32'd0;
      upd_count   <= 8'd0;
      timeout_err <= 1'b0;
    end else if (clk_en) begin
      r_upd_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            nd_r        <= node_dist;
            remaining_r <= edge_count;
            upd_count   <= 8'd0;
            timeout_err <= 1'b0;
            r_state     <= (edge_count == 8'd0) ? FINISH : FETCH;
          end
        end
        FETCH: begin
          if (edge_valid) begin
            r_weight   <= edge_weight;
            r_cur_dist <= edge_cur_dist;
            r_idx      <= edge_idx;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_wdog  <= 4'd0;
          r_state <= WAIT;
        end
        WAIT: begin
          // cs_done is only trusted here: the check-step may raise it
          // combinationally while cs_start is still high.
          if (cs_done) begin
            cand_r  <= cs_result;
            r_state <= EVAL;
          end else if (r_wdog == c_WDOG_LAST) begin
            // Infinity as the candidate guarantees no update for this edge.
            timeout_err <= 1'b1;
            cand_r      <= c_FP_INF;
            r_state     <= EVAL;
          end else begin
            r_wdog <= r_wdog + 4'd1;
          end
        end
        EVAL: begin
          if (w_improve) begin
            r_upd_valid <= 1'b1;
            upd_idx     <= r_idx;
            upd_dist    <= cand_r;
            if (upd_count != 8'hFF) begin
              upd_count <= upd_count + 8'd1;
            end
          end
          remaining_r <= remaining_r - 8'd1;
          r_state     <= (remaining_r == 8'd1) ? FINISH : FETCH;
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dijkstra_relax_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dijkstra_relax_ctrl
// Description : Directed self-checking bench for dijkstra_relax_ctrl with a
//               behavioural check-step model of programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dijkstra_relax_ctrl;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] node_dist;
  logic [7:0]  edge_count;
  logic        edge_valid;
  logic        edge_ready;
  logic [31:0] edge_weight;
  logic [31:0] edge_cur_dist;
  logic [7:0]  edge_idx;
  logic        cs_start;
  logic [31:0] cs_dataa;
  logic [31:0] cs_datab;
  logic        cs_done;
  logic [31:0] cs_result;
  logic        upd_valid;
  logic [7:0]  upd_idx;
  logic [31:0] upd_dist;
  logic        busy;
  logic        done;
  logic [7:0]  upd_count;
  logic        timeout_err;

  dijkstra_relax_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .clk_en       (clk_en),
    .start        (start),
    .node_dist    (node_dist),
    .edge_count   (edge_count),
    .edge_valid   (edge_valid),
    .edge_ready   (edge_ready),
    .edge_weight  (edge_weight),
    .edge_cur_dist(edge_cur_dist),
    .edge_idx     (edge_idx),
    .cs_start     (cs_start),
    .cs_dataa     (cs_dataa),
    .cs_datab     (cs_datab),
    .cs_done      (cs_done),
    .cs_result    (cs_result),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_idx),
    .upd_dist     (upd_dist),
    .busy         (busy),
    .done         (done),
    .upd_count    (upd_count),
    .timeout_err  (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Check-step model configuration (written by the stimulus only).
  int          cs_delay = 2;
  logic        cs_never = 1'b0;
  logic [31:0] res_tab [8];

  // Monitor state (written by the monitor only).
  int          upd_n = 0, cs_n = 0, done_n = 0;
  int          upd_cyc = 0, cs_cyc = 0, done_cyc = 0, tmo_cyc = 0;
  logic [7:0]  last_idx = 8'd0;
  logic [31:0] last_dist = 32'd0, cs_a = 32'd0, cs_b = 32'd0;
  logic        tmo_prev = 1'b0;
  int          cs_cnt = 0;

  // Per-pass baselines (written by the stimulus only).
  int b_upd = 0, b_cs = 0, b_done = 0, start_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor plus check-step model; done is held high once raised
  // and dropped when the next cs_start is seen.
  always @(negedge clk) begin
    if (upd_valid) begin
      upd_n++; last_idx = upd_idx; last_dist = upd_dist; upd_cyc = cyc;
    end
    if (done) begin
      done_n++; done_cyc = cyc;
    end
    if (timeout_err && !tmo_prev) tmo_cyc = cyc;
    tmo_prev = timeout_err;
    if (cs_cnt > 0) begin
      cs_cnt--;
      if (cs_cnt == 0) cs_done = 1'b1;
    end
    if (cs_start) begin
      cs_a = cs_dataa; cs_b = cs_datab; cs_cyc = cyc;
      cs_done   = 1'b0;
      cs_result = res_tab[(cs_n - b_cs) & 7];
      cs_n++;
      if (!cs_never) cs_cnt = cs_delay;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_pass(input logic [31:0] nd, input logic [7:0] n);
    @(negedge clk);
    b_upd = upd_n; b_cs = cs_n; b_done = done_n; start_cyc = cyc;
    node_dist = nd; edge_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for edge_ready, stalls for gap cycles, then offers one edge.
  task automatic send_edge(input logic [31:0] w, input logic [31:0] cd,
                           input logic [7:0] idx, input int gap);
    int t = 0;
    while (!edge_ready && t < 200) begin @(negedge clk); t++; end
    check("edge_ready", {31'd0, edge_ready}, 32'd1);
    repeat (gap) @(negedge clk);
    edge_weight = w; edge_cur_dist = cd; edge_idx = idx; edge_valid = 1'b1;
    @(negedge clk);
    edge_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((done_n - b_done) == 0 && t < 300) begin @(negedge clk); t++; end
    @(negedge clk);
    check("done_pulses", done_n - b_done, 32'd1);
  endtask

  task automatic single(input logic [31:0] cd, input logic [31:0] res, input int dly);
    res_tab[0] = res; cs_delay = dly;
    start_pass(32'h3F800000, 8'd1);
    send_edge(32'h40000000, cd, 8'd5, 0);
    wait_done();
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b1; start = 1'b0; node_dist = '0; edge_count = '0;
    edge_valid = 1'b0; edge_weight = '0; edge_cur_dist = '0; edge_idx = '0;
    cs_done = 1'b0; cs_result = '0;
    for (int i = 0; i < 8; i++) res_tab[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, edge_ready}, 32'd0);
    check("rst_csa",   cs_dataa, 32'd0);
    check("rst_csb",   cs_datab, 32'd0);
    check("rst_cnt",   {24'd0, upd_count}, 32'd0);
    check("rst_tmo",   {31'd0, timeout_err}, 32'd0);

    // Basic update: 1.0 + 2.0 = 3.0 < 4.0
    single(32'h40800000, 32'h40400000, 2);
    check("basic_upd_n", upd_n - b_upd, 32'd1);
    check("basic_idx",   {24'd0, last_idx}, 32'd5);
    check("basic_dist",  last_dist, 32'h40400000);
    check("basic_cnt",   {24'd0, upd_count}, 32'd1);
    check("basic_cs_n",  cs_n - b_cs, 32'd1);
    check("basic_csa",   cs_a, 32'h3F800000);
    check("basic_csb",   cs_b, 32'h40000000);
    check("basic_lat",   upd_cyc - cs_cyc, 32'd4);
    check("basic_busy",  {31'd0, busy}, 32'd0);

    // Equal candidate, infinite candidate, NaN current, infinite current
    single(32'h40400000, 32'h40400000, 2);
    check("eq_upd_n", upd_n - b_upd, 32'd0);
    check("eq_cnt",   {24'd0, upd_count}, 32'd0);
    single(32'h40400000, 32'h7F800000, 2);
    check("inf_upd_n", upd_n - b_upd, 32'd0);
    single(32'h7FC00000, 32'h40000000, 2);
    check("nan_upd_n", upd_n - b_upd, 32'd0);
    single(32'h7F800000, 32'h40000000, 1);
    check("infcur_upd_n", upd_n - b_upd, 32'd1);
    check("infcur_dist",  last_dist, 32'h40000000);

    // Three edges with stalls; the middle one does not improve
    res_tab[0] = 32'h40000000; res_tab[1] = 32'h41000000; res_tab[2] = 32'h3F000000;
    cs_delay = 2;
    start_pass(32'h3F800000, 8'd3);
    send_edge(32'h3F800000, 32'h40800000, 8'd1, 2);
    send_edge(32'h40000000, 32'h40800000, 8'd2, 2);
    send_edge(32'h3F000000, 32'h3F800000, 8'd3, 2);
    wait_done();
    check("multi_cs_n",  cs_n - b_cs, 32'd3);
    check("multi_upd_n", upd_n - b_upd, 32'd2);
    check("multi_idx",   {24'd0, last_idx}, 32'd3);
    check("multi_dist",  last_dist, 32'h3F000000);
    check("multi_cnt",   {24'd0, upd_count}, 32'd2);

    // Zero edges
    start_pass(32'h3F800000, 8'd0);
    wait_done();
    check("zero_cs_n", cs_n - b_cs, 32'd0);
    check("zero_lat",  done_cyc - start_cyc, 32'd2);
    check("zero_cnt",  {24'd0, upd_count}, 32'd0);

    // start pulsed during WAIT is ignored
    res_tab[0] = 32'h40400000; cs_delay = 5;
    start_pass(32'h3F800000, 8'd1);
    send_edge(32'h40000000, 32'h40800000, 8'd5, 0);
    repeat (2) @(negedge clk);
    node_dist = 32'd0; edge_count = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    check("sbusy_busy",  {31'd0, busy}, 32'd0);
    check("sbusy_cs_n",  cs_n - b_cs, 32'd1);
    check("sbusy_upd_n", upd_n - b_upd, 32'd1);
    check("sbusy_csa",   cs_a, 32'h3F800000);
    check("sbusy_cnt",   {24'd0, upd_count}, 32'd1);

    // Watchdog timeout, then done arriving on the eighth WAIT cycle
    cs_never = 1'b1;
    single(32'h40800000, 32'h40400000, 2);
    check("tmo_flag",  {31'd0, timeout_err}, 32'd1);
    check("tmo_lat",   tmo_cyc - cs_cyc, 32'd9);
    check("tmo_upd_n", upd_n - b_upd, 32'd0);
    cs_never = 1'b0;
    single(32'h40800000, 32'h40400000, 8);
    check("w8_tmo",   {31'd0, timeout_err}, 32'd0);
    check("w8_upd_n", upd_n - b_upd, 32'd1);
    check("w8_lat",   upd_cyc - cs_cyc, 32'd10);

    // Reset while in WAIT; the late cs_done must be ignored
    res_tab[0] = 32'h40400000; cs_delay = 6;
    start_pass(32'h3F800000, 8'd1);
    send_edge(32'h40000000, 32'h40800000, 8'd5, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstw_busy", {31'd0, busy}, 32'd0);
    check("rstw_csa",  cs_dataa, 32'd0);
    repeat (10) @(negedge clk);
    check("rstw_busy2", {31'd0, busy}, 32'd0);
    check("rstw_upd_n", upd_n - b_upd, 32'd0);
    check("rstw_done",  done_n - b_done, 32'd0);

    // clk_en low for 5 cycles during WAIT
    res_tab[0] = 32'h40400000; cs_delay = 3;
    start_pass(32'h3F800000, 8'd1);
    send_edge(32'h40000000, 32'h40800000, 8'd5, 0);
    @(negedge clk);
    clk_en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("frz_busy",  {31'd0, busy}, 32'd1);
      check("frz_start", {31'd0, cs_start}, 32'd0);
    end
    clk_en = 1'b1;
    wait_done();
    check("frz_upd_n", upd_n - b_upd, 32'd1);
    check("frz_idx",   {24'd0, last_idx}, 32'd5);
    check("frz_dist",  last_dist, 32'h40400000);
    check("frz_cnt",   {24'd0, upd_count}, 32'd1);
    check("frz_tmo",   {31'd0, timeout_err}, 32'd0);
    check("frz_lat",   upd_cyc - cs_cyc, 32'd8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dijkstra_relax_ctrl.md
DIJKSTRA_RELAX_CTRL -- requirements
Module: dijkstra_relax_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; reset  in  1  synchronous, active-high reset; clk_en  in  1  clock enable; all state advances only when clk_en=1.
REQ-002 SHALL have ports: start  in  1  begin a relaxation pass; node_dist  in  32  IEEE-754 single, distance of the node being expanded; edge_count  in  8  number of edges in the pass.
REQ-003 SHALL have edge-stream ports: edge_valid  in  1; edge_ready  out  1; edge_weight  in  32  float; edge_cur_dist  in  32  float, current neighbour distance; edge_idx  in  8  neighbour index.
REQ-004 SHALL have check-step ports: cs_start  out  1; cs_dataa  out  32; cs_datab  out  32; cs_done  in  1; cs_result  in  32.
REQ-005 SHALL have output ports: upd_valid  out  1; upd_idx  out  8; upd_dist  out  32; busy  out  1; done  out  1; upd_count  out  8; timeout_err  out  1.

Function
REQ-006 SHALL implement FSM states IDLE, FETCH, ISSUE, WAIT, EVAL, FINISH.
REQ-007 IDLE: start=1 SHALL latch node_dist into nd_r and edge_count into remaining_r, clear upd_count and timeout_err, and go to FETCH; if edge_count=0, go to FINISH instead.
REQ-008 start while not IDLE SHALL be ignored; parameters SHALL not change mid-pass.
REQ-009 FETCH: edge_ready=1 only in this state; edge_valid=1 SHALL latch weight, cur_dist and idx, then go to ISSUE; otherwise stay in FETCH.
REQ-010 ISSUE: cs_start=1 for exactly one enabled cycle, then go to WAIT.
REQ-011 cs_dataa=nd_r and cs_datab=latched weight SHALL be held stable from ISSUE through WAIT; both SHALL be 0 in IDLE.
REQ-012 WAIT: cs_done SHALL be sampled only in this state, never in ISSUE, since the check-step can raise done combinationally.
REQ-013 WAIT: when cs_done=1, cs_result SHALL be latched into cand_r and the FSM SHALL go to EVAL.
REQ-014 WAIT SHALL run a 4-bit watchdog counter. If cs_done is not seen within 8 enabled cycles, the FSM SHALL set sticky timeout_err, treat the edge as not improved and go to EVAL.
REQ-015 EVAL: an update SHALL occur iff cand_r<=32'h7F800000, edge_cur_dist<=32'h7F800000, and cand_r < cur_dist as an unsigned 32-bit compare; this compare is valid for non-negative floats.
REQ-016 Equal values, a candidate of infinity (7F800000) and NaN encodings SHALL produce no update.
REQ-017 On update, upd_valid SHALL be high for exactly one cycle, with upd_idx=latched idx and upd_dist=cand_r; upd_count SHALL increment and saturate at 255.
REQ-018 EVAL SHALL decrement remaining_r. If the result is 0 the FSM SHALL go to FINISH, else to FETCH.
REQ-019 FINISH: done=1 for one cycle, then go to IDLE; upd_count and timeout_err SHALL hold until the next accepted start.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 With clk_en=0 all registers SHALL hold, and cs_start, upd_valid and done SHALL be forced to 0.
REQ-022 Per-edge latency SHALL be 1 (FETCH) + 1 (ISSUE) + N (WAIT, where N = cycles to cs_done, N>=1) + 1 (EVAL) enabled cycles.

Reset
REQ-023 reset=1 on a clk edge SHALL force IDLE regardless of clk_en or current state, including mid-WAIT.
REQ-024 reset SHALL clear: all outputs to 0, nd_r, remaining_r, the latches and the watchdog counter.
REQ-025 A cs_done arriving after a reset SHALL be ignored because the FSM is in IDLE.

Verification
REQ-026 Basic update: node_dist=3F800000, one edge with weight 40000000, cur_dist 40800000, check-step model returns 40400000 two cycles after cs_start -> one upd_valid pulse with idx, dist 40400000; done; upd_count=1.
REQ-027 No improvement: same stimulus with cur_dist=40400000 (equal) -> no upd_valid, done, upd_count=0; repeat with cs_result=7F800000 -> no update.
REQ-028 Multi-edge with stalls: edge_count=3, edge_valid deasserted for 2 cycles between edges -> exactly 3 cs_start pulses, updates only for edges whose result is below cur_dist, done after the third EVAL.
REQ-029 Zero edges and start while busy: edge_count=0 -> done 2 cycles after start, no cs_start; start pulsed during WAIT -> ignored, pass completes unchanged.
REQ-030 Timeout: cs_done never asserted -> timeout_err=1 after 8 WAIT cycles, no update, pass continues to done.
REQ-031 Reset and clk_en: reset asserted in WAIT -> busy=0 next cycle, a late cs_done is ignored; clk_en=0 for 5 cycles mid-pass -> state frozen, and the pass then completes with identical results.
